// File: rtl/nes_palette_pkg.sv
// Shared NES palette types, the RGB444 colour table and the colour-distance helper.
// The table matches the palette-to-RGB converter entry for entry.
package nes_palette_pkg;

  typedef logic [11:0] rgb444_t;
  typedef logic [5:0]  pal_idx_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } enc_state_t;

  localparam rgb444_t NES_PALETTE [64] = '{
    12'h777, 12'h018, 12'h20a, 12'h409, 12'h607, 12'h703, 12'h710, 12'h520,
    12'h330, 12'h140, 12'h040, 12'h041, 12'h135, 12'h000, 12'h000, 12'h000,
    12'hbbb, 12'h05e, 12'h33f, 12'h71f, 12'ha0b, 12'hc05, 12'hd30, 12'ha50,
    12'h870, 12'h390, 12'h0a0, 12'h0a3, 12'h088, 12'h000, 12'h000, 12'h000,
    12'hfff, 12'h3bf, 12'h69f, 12'ha8f, 12'he6f, 12'hf6a, 12'hf85, 12'hea2,
    12'hcb0, 12'h8d1, 12'h4d4, 12'h3d8, 12'h0ed, 12'h777, 12'h000, 12'h000,
    12'hfff, 12'haef, 12'hbcf, 12'hdbf, 12'hfbf, 12'hfbd, 12'hfcb, 12'hfdb,
    12'heea, 12'hcf9, 12'hafa, 12'haeb, 12'h9ff, 12'hbbb, 12'h000, 12'h000
  };

  function automatic logic [9:0] chan_sq(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] d;
    d = (a > b) ? (a - b) : (b - a);
    return {6'b0, d} * {6'b0, d};
  endfunction

  // Squared Euclidean distance; worst case 3*15^2 = 675 fits in 10 bits.
  function automatic logic [9:0] rgb_dist(input rgb444_t a, input rgb444_t b);
    return chan_sq(a[11:8], b[11:8]) + chan_sq(a[7:4], b[7:4]) + chan_sq(a[3:0], b[3:0]);
  endfunction

endpackage

// File: rtl/nes_palette_rom.sv
// Combinational palette lookup: 6-bit NES index to its RGB444 colour.
module nes_palette_rom
  import nes_palette_pkg::*;
(
  input  pal_idx_t idx,
  output rgb444_t  rgb
);

  assign rgb = NES_PALETTE[idx];

endmodule

// File: rtl/rgb_palette_encoder.sv
// Nearest-colour search: maps an RGB444 colour to the closest NES palette index,
// scanning PAR entries per cycle with the lowest index winning any tie.
module rgb_palette_encoder
  import nes_palette_pkg::*;
#(
  parameter int PAR        = 1,
  parameter int EARLY_EXIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [11:0] in_rgb,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_index,
  output logic [9:0]  out_dist
);

  localparam pal_idx_t STEP     = pal_idx_t'(PAR);
  localparam pal_idx_t LAST_IDX = pal_idx_t'(64 - PAR);

  enc_state_t state, state_nxt;
  rgb444_t    rgb_q;
  pal_idx_t   idx;
  pal_idx_t   best_idx;
  logic [9:0] best_dist;

  rgb444_t    pal_rgb   [PAR];
  logic [9:0] cand_dist [PAR];
  pal_idx_t   grp_idx;
  logic [9:0] grp_dist;
  logic       grp_hit;
  logic       search_end;

  for (genvar i = 0; i < PAR; i++) begin : g_lane
    nes_palette_rom u_rom (
      .idx (idx + pal_idx_t'(i)),
      .rgb (pal_rgb[i])
    );
    assign cand_dist[i] = rgb_dist(rgb_q, pal_rgb[i]);
  end

  // Strict compare in ascending lane order keeps the lower index on ties.
  always_comb begin
    grp_dist = best_dist;
    grp_idx  = best_idx;
    grp_hit  = 1'b0;
    for (int i = 0; i < PAR; i++) begin
      if (cand_dist[i] < grp_dist) begin
        grp_dist = cand_dist[i];
        grp_idx  = idx + pal_idx_t'(i);
      end
      if (cand_dist[i] == 10'd0) grp_hit = 1'b1;
    end
  end

  assign search_end = (idx == LAST_IDX) || ((EARLY_EXIT != 0) && grp_hit);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = SEARCH;
      SEARCH:  if (search_end) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default:                 state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rgb_q     <= '0;
      idx       <= '0;
      best_idx  <= '0;
      best_dist <= 10'h3FF;
      out_index <= '0;
      out_dist  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            rgb_q     <= in_rgb;
            idx       <= '0;
            best_idx  <= '0;
            best_dist <= 10'h3FF;
          end
        end
        SEARCH: begin
          idx       <= idx + STEP;
          best_idx  <= grp_idx;
          best_dist <= grp_dist;
          if (search_end) begin
            out_index <= grp_idx;
            out_dist  <= grp_dist;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rgb_palette_encoder.sv
// Directed bench for rgb_palette_encoder across several PAR/EARLY_EXIT builds,
// with an independent nearest-colour model for cross-checks.
module tb_rgb_palette_encoder;
  import nes_palette_pkg::*;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid  [N];
  logic        in_ready  [N];
  logic [11:0] in_rgb    [N];
  logic        out_valid [N];
  logic        out_ready [N];
  logic [5:0]  out_index [N];
  logic [9:0]  out_dist  [N];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // 0: PAR1 full, 1: PAR1 early exit, 2: PAR2 full, 3: PAR8 full
  rgb_palette_encoder #(.PAR(1), .EARLY_EXIT(0)) dut_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_rgb(in_rgb[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_index(out_index[0]), .out_dist(out_dist[0]));
  rgb_palette_encoder #(.PAR(1), .EARLY_EXIT(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_rgb(in_rgb[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_index(out_index[1]), .out_dist(out_dist[1]));
  rgb_palette_encoder #(.PAR(2), .EARLY_EXIT(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_rgb(in_rgb[2]),
    .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_index(out_index[2]), .out_dist(out_dist[2]));
  rgb_palette_encoder #(.PAR(8), .EARLY_EXIT(0)) dut_d (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[3]), .in_ready(in_ready[3]), .in_rgb(in_rgb[3]),
    .out_valid(out_valid[3]), .out_ready(out_ready[3]), .out_index(out_index[3]), .out_dist(out_dist[3]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Brute-force nearest colour with integer arithmetic; first minimum wins.
  function automatic void model(input logic [11:0] rgb, output logic [5:0] mi, output logic [9:0] md);
    int best, d, dr, dg, db;
    logic [11:0] p;
    best = 1 << 20;
    mi = '0;
    for (int k = 0; k < 64; k++) begin
      p  = NES_PALETTE[k];
      dr = int'(rgb[11:8]) - int'(p[11:8]);
      dg = int'(rgb[7:4])  - int'(p[7:4]);
      db = int'(rgb[3:0])  - int'(p[3:0]);
      d  = dr*dr + dg*dg + db*db;
      if (d < best) begin
        best = d;
        mi   = 6'(k);
      end
    end
    md = 10'(best);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction; lat = edges from acceptance until out_valid is seen.
  task automatic run(input int d, input logic [11:0] rgb,
                     output logic [5:0] oi, output logic [9:0] od, output int lat);
    int w;
    w = 0;
    in_rgb[d]   = rgb;
    in_valid[d] = 1'b1;
    while (!in_ready[d] && w < 200) begin
      tick();
      w++;
    end
    tick();
    in_valid[d] = 1'b0;
    lat = 0;
    while (!out_valid[d] && lat < 200) begin
      tick();
      lat++;
    end
    chk("timeout", {31'b0, out_valid[d]}, 32'd1);
    oi = out_index[d];
    od = out_dist[d];
    out_ready[d] = 1'b1;
    tick();
    out_ready[d] = 1'b0;
  endtask

  initial begin
    logic [5:0] oi, mi, ri;
    logic [9:0] od, md, rd;
    logic [5:0] hold_i;
    logic [9:0] hold_d;
    int lat, w;
    bit ok;

    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid[i]  = 1'b0;
      in_rgb[i]    = '0;
      out_ready[i] = 1'b0;
    end
    tick();
    chk("rst_in_ready",  {31'b0, in_ready[0]},  32'd1);
    chk("rst_out_valid", {31'b0, out_valid[0]}, 32'd0);
    chk("rst_out_index", {26'b0, out_index[3]}, 32'd0);
    chk("rst_out_dist",  {22'b0, out_dist[3]},  32'd0);
    rst_n = 1'b1;
    tick();

    // Full search on a colour that exactly matches entry 0 (and its duplicate 0x2d).
    run(0, 12'h777, oi, od, lat);
    chk("a777_idx", {26'b0, oi}, 32'h00);
    chk("a777_dist", {22'b0, od}, 32'd0);
    chk("a777_lat", lat, 32'd64);

    run(1, 12'h000, oi, od, lat);
    chk("b000_idx", {26'b0, oi}, 32'h0d);
    chk("b000_dist", {22'b0, od}, 32'd0);
    chk("b000_lat", lat, 32'd14);

    run(1, 12'hfff, oi, od, lat);
    chk("bfff_idx", {26'b0, oi}, 32'h20);
    chk("bfff_lat", lat, 32'd33);

    run(1, 12'hbbb, oi, od, lat);
    chk("bbbb_idx", {26'b0, oi}, 32'h10);
    chk("bbbb_lat", lat, 32'd17);

    run(1, 12'h777, oi, od, lat);
    chk("b777_idx", {26'b0, oi}, 32'h00);
    chk("b777_lat", lat, 32'd1);

    run(0, 12'h001, oi, od, lat);
    chk("a001_idx", {26'b0, oi}, 32'h0d);
    chk("a001_dist", {22'b0, od}, 32'd1);

    // e10 vs d30: dr=1, dg=2, db=0 -> 5; no other entry is as close.
    run(0, 12'he10, oi, od, lat);
    model(12'he10, mi, md);
    chk("ae10_idx", {26'b0, oi}, 32'h16);
    chk("ae10_dist", {22'b0, od}, 32'd5);
    chk("ae10_model_idx", {26'b0, oi}, {26'b0, mi});

    // Back-pressure, with a stray busy-time input that must be ignored.
    in_rgb[1]   = 12'h135;
    in_valid[1] = 1'b1;
    tick();
    in_rgb[1] = 12'hfff;
    w = 0;
    while (!out_valid[1] && w < 200) begin
      tick();
      w++;
    end
    in_valid[1] = 1'b0;
    chk("bp_valid", {31'b0, out_valid[1]}, 32'd1);
    chk("bp_idx", {26'b0, out_index[1]}, 32'h0c);
    hold_i = out_index[1];
    hold_d = out_dist[1];
    ok = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (out_index[1] !== hold_i || out_dist[1] !== hold_d || in_ready[1] !== 1'b0 || out_valid[1] !== 1'b1)
        ok = 1'b0;
    end
    chk("bp_hold", {31'b0, ok}, 32'd1);
    out_ready[1] = 1'b1;
    tick();
    out_ready[1] = 1'b0;
    chk("bp_rel_valid", {31'b0, out_valid[1]}, 32'd0);
    chk("bp_rel_ready", {31'b0, in_ready[1]}, 32'd1);

    // Reset mid-search abandons the result.
    in_rgb[0]   = 12'h555;
    in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    for (int c = 0; c < 10; c++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("mrst_in_ready",  {31'b0, in_ready[0]},  32'd1);
    chk("mrst_out_valid", {31'b0, out_valid[0]}, 32'd0);
    chk("mrst_out_index", {26'b0, out_index[0]}, 32'd0);
    chk("mrst_out_dist",  {22'b0, out_dist[0]},  32'd0);
    ok = 1'b1;
    for (int c = 0; c < 80; c++) begin
      tick();
      if (out_valid[0] !== 1'b0) ok = 1'b0;
    end
    chk("mrst_no_stale", {31'b0, ok}, 32'd1);

    // Sweep: every colour on PAR8, a stride-16 subset also on PAR1 and PAR2.
    for (int v = 0; v < 4096; v++) begin
      model(12'(v), mi, md);
      run(3, 12'(v), oi, od, lat);
      chk("sw8_idx", {20'b0, 12'(v), oi}, {20'b0, 12'(v), mi});
      chk("sw8_dist", {20'b0, od, 2'b0}, {20'b0, md, 2'b0});
      if (v % 16 == 5) begin
        chk("sw8_lat", lat, 32'd8);
        run(0, 12'(v), ri, rd, lat);
        chk("sw1_idx", {20'b0, 12'(v), ri}, {20'b0, 12'(v), oi});
        chk("sw1_dist", {22'b0, rd}, {22'b0, md});
        run(2, 12'(v), ri, rd, lat);
        chk("sw2_idx", {20'b0, 12'(v), ri}, {20'b0, 12'(v), oi});
        chk("sw2_dist", {22'b0, rd}, {22'b0, md});
        chk("sw2_lat", lat, 32'd32);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
